// File: rtl/video_timing_gen_if.sv
// Raster timing bundle from video_timing_gen to the sprite stage / HDMI encoder.
// Latency: n/a (signal grouping only); every field is driven from a register.
// Backpressure: none, the stream is free-running and has no ready signal.
interface video_timing_gen_if;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic        hs_out;
    logic        vs_out;
    logic        ad_out;
    logic        nf_out;
    logic [5:0]  fc_out;
    logic        hs_dly_out;
    logic        vs_dly_out;
    logic        ad_dly_out;

    modport master (
        output hcount_out, vcount_out, hs_out, vs_out, ad_out, nf_out, fc_out,
        output hs_dly_out, vs_dly_out, ad_dly_out
    );
    modport slave (
        input hcount_out, vcount_out, hs_out, vs_out, ad_out, nf_out, fc_out,
        input hs_dly_out, vs_dly_out, ad_dly_out
    );
endinterface

// File: rtl/video_timing_gen.sv
// 1280x720@60 raster timing: counters, syncs, active-draw, new-frame strobe, frame count.
// Latency: flags share the counters' register stage; *_dly_out lag SYNC_DELAY cycles when VTG_SYNC_DELAY_EN is defined.
// Backpressure: none, free-running every pixel clock.
module video_timing_gen #(
    parameter int ACTIVE_H      = 1280,
    parameter int H_FRONT_PORCH = 110,
    parameter int H_SYNC_WIDTH  = 40,
    parameter int H_BACK_PORCH  = 220,
    parameter int ACTIVE_V      = 720,
    parameter int V_FRONT_PORCH = 5,
    parameter int V_SYNC_WIDTH  = 5,
    parameter int V_BACK_PORCH  = 20,
    parameter int FRAME_WRAP    = 60,
    parameter int SYNC_DELAY    = 4
) (
    input  logic              pixel_clk_in,
    input  logic              rst_in,
    video_timing_gen_if.master vtg
);
    localparam int TOTAL_H = ACTIVE_H + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
    localparam int TOTAL_V = ACTIVE_V + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;

    localparam logic [10:0] H_LAST   = 11'(TOTAL_H - 1);
    localparam logic [10:0] H_ACT    = 11'(ACTIVE_H);
    localparam logic [10:0] HS_START = 11'(ACTIVE_H + H_FRONT_PORCH);
    localparam logic [10:0] HS_END   = 11'(ACTIVE_H + H_FRONT_PORCH + H_SYNC_WIDTH);
    localparam logic [9:0]  V_LAST   = 10'(TOTAL_V - 1);
    localparam logic [9:0]  V_ACT    = 10'(ACTIVE_V);
    localparam logic [9:0]  VS_START = 10'(ACTIVE_V + V_FRONT_PORCH);
    localparam logic [9:0]  VS_END   = 10'(ACTIVE_V + V_FRONT_PORCH + V_SYNC_WIDTH);
    localparam logic [5:0]  FC_LAST  = 6'(FRAME_WRAP - 1);

    logic [10:0] hcount_q, hcount_d;
    logic [9:0]  vcount_q, vcount_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        ad_q, ad_d;
    logic        nf_q, nf_d;
    logic [5:0]  fc_q, fc_d;

    // Advance the raster position and decode every flag from the *next* position,
    // so counters and flags land in the same register stage with no skew.
    always_comb begin
        hcount_d = hcount_q + 11'd1;
        vcount_d = vcount_q;
        if (hcount_q == H_LAST) begin
            hcount_d = '0;
            vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
        end
        ad_d = (hcount_d < H_ACT) && (vcount_d < V_ACT);
        hs_d = (hcount_d >= HS_START) && (hcount_d < HS_END);
        vs_d = (vcount_d >= VS_START) && (vcount_d < VS_END);
        nf_d = (hcount_d == '0) && (vcount_d == V_ACT);
        fc_d = fc_q;
        if (nf_d) begin
            fc_d = (fc_q == FC_LAST) ? '0 : fc_q + 6'd1;
        end
    end

    // Reset parks the counters on the last pixel so the first free edge shows (0,0).
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            hcount_q <= H_LAST;
            vcount_q <= V_LAST;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            ad_q     <= 1'b0;
            nf_q     <= 1'b0;
            fc_q     <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            ad_q     <= ad_d;
            nf_q     <= nf_d;
            fc_q     <= fc_d;
        end
    end

    assign vtg.hcount_out = hcount_q;
    assign vtg.vcount_out = vcount_q;
    assign vtg.hs_out     = hs_q;
    assign vtg.vs_out     = vs_q;
    assign vtg.ad_out     = ad_q;
    assign vtg.nf_out     = nf_q;
    assign vtg.fc_out     = fc_q;

`ifdef VTG_SYNC_DELAY_EN
    // Each stage holds {hs, vs, ad}; stage 0 takes the registered flags.
    logic [SYNC_DELAY-1:0][2:0] dly_q, dly_d;

    // Shift the flag triple one stage per pixel to match the sprite pipeline depth.
    always_comb begin
        dly_d    = dly_q;
        dly_d[0] = {hs_q, vs_q, ad_q};
        for (int i = 1; i < SYNC_DELAY; i++) begin
            dly_d[i] = dly_q[i-1];
        end
    end

    // Pipeline clears with the counters so no stale sync escapes after reset.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            dly_q <= '0;
        end else begin
            dly_q <= dly_d;
        end
    end

    assign vtg.hs_dly_out = dly_q[SYNC_DELAY-1][2];
    assign vtg.vs_dly_out = dly_q[SYNC_DELAY-1][1];
    assign vtg.ad_dly_out = dly_q[SYNC_DELAY-1][0];
`else
    assign vtg.hs_dly_out = hs_q;
    assign vtg.vs_dly_out = vs_q;
    assign vtg.ad_dly_out = ad_q;
`endif
endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: full-size instance for line-level timing, reduced-geometry
// instance for frame wrap, 60-frame counter sequence and mid-frame reset.
// Expected responses are queued up front; per-instance monitors pop them on the matching cycle.
module tb_video_timing_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_f, rst_s;
    logic go;

    video_timing_gen_if vf ();
    video_timing_gen_if vm ();

    video_timing_gen dut_full (
        .pixel_clk_in (clk),
        .rst_in       (rst_f),
        .vtg          (vf)
    );

    // Small raster: TOTAL_H=17 (hs at 10..12), TOTAL_V=13 (vs lines 8..9), nf at (0,6).
    video_timing_gen #(
        .ACTIVE_H(8), .H_FRONT_PORCH(2), .H_SYNC_WIDTH(3), .H_BACK_PORCH(4),
        .ACTIVE_V(6), .V_FRONT_PORCH(2), .V_SYNC_WIDTH(2), .V_BACK_PORCH(3),
        .FRAME_WRAP(60), .SYNC_DELAY(4)
    ) dut_small (
        .pixel_clk_in (clk),
        .rst_in       (rst_s),
        .vtg          (vm)
    );

    localparam int C_RST = 13537;   // small-raster cycle showing (5,3) in frame 61

    typedef struct {
        int cyc; int h; int v;
        bit hs; bit vs; bit ad; bit nf; int fc;
        bit chk_dly; bit hsd; bit vsd; bit add;
    } exp_t;

    exp_t q_full[$];
    exp_t q_small[$];

    int n_chk  = 0;
    int n_pass = 0;

    int f_hs_cnt = 0, f_hsd_cnt = 0, f_dly_bad = 0;
    int s_hs_cnt = 0, s_vs_cnt = 0, s_nf_cnt = 0, s_nf_wide = 0;

    task automatic chk(input string name, input int cyc, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
    endtask

    task automatic push_full(input int cyc, input int h, input int v, input bit hs, input bit vs,
                             input bit ad, input bit nf, input int fc,
                             input bit hsd, input bit vsd, input bit add);
        exp_t e;
        e = '{cyc, h, v, hs, vs, ad, nf, fc, 1'b1, hsd, vsd, add};
`ifndef VTG_SYNC_DELAY_EN
        e.hsd = hs; e.vsd = vs; e.add = ad;
`endif
        q_full.push_back(e);
    endtask

    task automatic push_small(input int cyc, input int h, input int v, input bit hs, input bit vs,
                              input bit ad, input bit nf, input int fc);
        q_small.push_back('{cyc, h, v, hs, vs, ad, nf, fc, 1'b0, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic cmp(input string tag, input exp_t e, input int h, input int v, input bit hs,
                       input bit vs, input bit ad, input bit nf, input int fc,
                       input bit hsd, input bit vsd, input bit add);
        chk({tag, "_hcount"}, e.cyc, h, e.h);
        chk({tag, "_vcount"}, e.cyc, v, e.v);
        chk({tag, "_hs"}, e.cyc, int'(hs), int'(e.hs));
        chk({tag, "_vs"}, e.cyc, int'(vs), int'(e.vs));
        chk({tag, "_ad"}, e.cyc, int'(ad), int'(e.ad));
        chk({tag, "_nf"}, e.cyc, int'(nf), int'(e.nf));
        chk({tag, "_fc"}, e.cyc, fc, e.fc);
        if (e.chk_dly) begin
            chk({tag, "_hs_dly"}, e.cyc, int'(hsd), int'(e.hsd));
            chk({tag, "_vs_dly"}, e.cyc, int'(vsd), int'(e.vsd));
            chk({tag, "_ad_dly"}, e.cyc, int'(add), int'(e.add));
        end
    endtask

    // Monitor for the full-size instance: directed vectors plus line-0 sync counts and
    // a cycle-by-cycle check of the delayed outputs against the undelayed ones.
    initial begin
        int cyc;
        exp_t e;
        bit [2:0] hist [4];
        bit [2:0] cur, dexp, dact;
        cyc = 0;
        for (int i = 0; i < 4; i++) hist[i] = 3'b000;
        wait (go);
        forever begin
            @(negedge clk);
            if (q_full.size() > 0 && q_full[0].cyc == cyc) begin
                e = q_full.pop_front();
                cmp("full", e, int'(vf.hcount_out), int'(vf.vcount_out), vf.hs_out, vf.vs_out,
                    vf.ad_out, vf.nf_out, int'(vf.fc_out), vf.hs_dly_out, vf.vs_dly_out, vf.ad_dly_out);
            end
            if (cyc < 1650) begin
                f_hs_cnt  += int'(vf.hs_out);
                f_hsd_cnt += int'(vf.hs_dly_out);
            end
            cur  = {vf.hs_out, vf.vs_out, vf.ad_out};
            dact = {vf.hs_dly_out, vf.vs_dly_out, vf.ad_dly_out};
`ifdef VTG_SYNC_DELAY_EN
            dexp = hist[3];
`else
            dexp = cur;
`endif
            if (dact != dexp) f_dly_bad++;
            hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = cur;
            cyc++;
        end
    end

    // Monitor for the small instance: directed vectors, frame-0 sync counts and the
    // frame-counter sequence at every new-frame pulse before the mid-frame reset.
    initial begin
        int cyc;
        exp_t e;
        bit prev_nf;
        cyc = 0;
        prev_nf = 1'b0;
        wait (go);
        forever begin
            @(negedge clk);
            if (q_small.size() > 0 && q_small[0].cyc == cyc) begin
                e = q_small.pop_front();
                cmp("small", e, int'(vm.hcount_out), int'(vm.vcount_out), vm.hs_out, vm.vs_out,
                    vm.ad_out, vm.nf_out, int'(vm.fc_out), 1'b0, 1'b0, 1'b0);
            end
            if (cyc < 221) begin
                s_hs_cnt += int'(vm.hs_out);
                s_vs_cnt += int'(vm.vs_out);
            end
            if (cyc <= C_RST) begin
                if (vm.nf_out) begin
                    s_nf_cnt++;
                    chk("fc_seq", cyc, int'(vm.fc_out), s_nf_cnt % 60);
                end
                if (vm.nf_out && prev_nf) s_nf_wide++;
            end
            prev_nf = vm.nf_out;
            cyc++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_f = 1'b1;
        rst_s = 1'b1;
        go    = 1'b0;

        // Full raster, cycle numbers counted from the first free edge.
        //        cyc   h     v  hs vs ad nf fc  hsd vsd add
        push_full(0,    0,    0, 0, 0, 1, 0, 0,  0,  0,  0);
        push_full(3,    3,    0, 0, 0, 1, 0, 0,  0,  0,  0);
        push_full(4,    4,    0, 0, 0, 1, 0, 0,  0,  0,  1);
        push_full(1279, 1279, 0, 0, 0, 1, 0, 0,  0,  0,  1);
        push_full(1280, 1280, 0, 0, 0, 0, 0, 0,  0,  0,  1);
        push_full(1283, 1283, 0, 0, 0, 0, 0, 0,  0,  0,  1);
        push_full(1284, 1284, 0, 0, 0, 0, 0, 0,  0,  0,  0);
        push_full(1389, 1389, 0, 0, 0, 0, 0, 0,  0,  0,  0);
        push_full(1390, 1390, 0, 1, 0, 0, 0, 0,  0,  0,  0);
        push_full(1393, 1393, 0, 1, 0, 0, 0, 0,  0,  0,  0);
        push_full(1394, 1394, 0, 1, 0, 0, 0, 0,  1,  0,  0);
        push_full(1429, 1429, 0, 1, 0, 0, 0, 0,  1,  0,  0);
        push_full(1430, 1430, 0, 0, 0, 0, 0, 0,  1,  0,  0);
        push_full(1433, 1433, 0, 0, 0, 0, 0, 0,  1,  0,  0);
        push_full(1434, 1434, 0, 0, 0, 0, 0, 0,  0,  0,  0);
        push_full(1649, 1649, 0, 0, 0, 0, 0, 0,  0,  0,  0);
        push_full(1650, 0,    1, 0, 0, 1, 0, 0,  0,  0,  0);
        push_full(1654, 4,    1, 0, 0, 1, 0, 0,  0,  0,  1);

        // Small raster (17 x 13, frame = 221 cycles).
        //         cyc     h   v  hs vs ad nf fc
        push_small(0,      0,  0, 0, 0, 1, 0, 0);
        push_small(7,      7,  0, 0, 0, 1, 0, 0);
        push_small(9,      9,  0, 0, 0, 0, 0, 0);
        push_small(10,     10, 0, 1, 0, 0, 0, 0);
        push_small(12,     12, 0, 1, 0, 0, 0, 0);
        push_small(13,     13, 0, 0, 0, 0, 0, 0);
        push_small(101,    16, 5, 0, 0, 0, 0, 0);
        push_small(102,    0,  6, 0, 0, 0, 1, 1);
        push_small(103,    1,  6, 0, 0, 0, 0, 1);
        push_small(135,    16, 7, 0, 0, 0, 0, 1);
        push_small(136,    0,  8, 0, 1, 0, 0, 1);
        push_small(169,    16, 9, 0, 1, 0, 0, 1);
        push_small(170,    0, 10, 0, 0, 0, 0, 1);
        push_small(220,    16,12, 0, 0, 0, 0, 1);
        push_small(221,    0,  0, 0, 0, 1, 0, 1);
        push_small(13140,  16, 5, 0, 0, 0, 0, 59);
        push_small(13141,  0,  6, 0, 0, 0, 1, 0);
        push_small(C_RST,  5,  3, 0, 0, 1, 0, 1);
        push_small(C_RST+1,16,12, 0, 0, 0, 0, 0);
        push_small(C_RST+2,0,  0, 0, 0, 1, 0, 0);
        push_small(C_RST+104,0,6, 0, 0, 0, 1, 1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hcount", -1, int'(vf.hcount_out), 1649);
        chk("rst_vcount", -1, int'(vf.vcount_out), 749);
        chk("rst_flags",  -1, int'({vf.hs_out, vf.vs_out, vf.ad_out, vf.nf_out}), 0);
        chk("rst_fc",     -1, int'(vf.fc_out), 0);
        chk("rst_dly",    -1, int'({vf.hs_dly_out, vf.vs_dly_out, vf.ad_dly_out}), 0);
        chk("rst_small_pos", -1, int'(vm.hcount_out) * 100 + int'(vm.vcount_out), 1612);

        rst_f = 1'b0;
        rst_s = 1'b0;
        go    = 1'b1;

        repeat (C_RST + 1) @(negedge clk);
        rst_s = 1'b1;
        @(negedge clk);
        rst_s = 1'b0;
        repeat (200) @(negedge clk);

        chk("full_vectors_seen",  0, q_full.size(), 0);
        chk("small_vectors_seen", 0, q_small.size(), 0);
        chk("full_hs_width",      0, f_hs_cnt, 40);
        chk("full_hs_dly_width",  0, f_hsd_cnt, 40);
        chk("full_dly_track",     0, f_dly_bad, 0);
        chk("small_hs_frame",     0, s_hs_cnt, 39);
        chk("small_vs_frame",     0, s_vs_cnt, 34);
        chk("small_nf_pulses",    0, s_nf_cnt, 61);
        chk("small_nf_width",     0, s_nf_wide, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
